iob_aoi_sched: RTL and testbench
================================

# iob_aoi_sched

Shared-resource scheduler for a single `iob_aoi` datapath. It accepts W-bit operand sets (a, b, c, d) from N_REQ requesters over valid/ready handshakes and arbitrates round-robin between them. It issues one operation at a time to the AOI and returns the registered result `y = ~((a & b) | (c & d))`, tagged with the requester index, on a valid/ready output port. It sits between several producer blocks and one `iob_aoi` instance, so the gate is time-multiplexed rather than duplicated.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, minimum 2.
- `W`, default 1: operand and result width, passed to `iob_aoi`.
- Derived localparam `ID_W = $clog2(N_REQ)`.

Ports:
- `clk_i` input, 1: clock. All logic is on the rising edge.
- `rst_n_i` input, 1: reset, synchronous and active-low.
- `req_valid_i` input, N_REQ: per-requester request valid.
- `req_ready_o` output, N_REQ: per-requester grant/accept, one-hot or zero.
- `req_a_i` input, N_REQ*W: operand a, requester k at bits [k*W +: W].
- `req_b_i` input, N_REQ*W: operand b, same packing.
- `req_c_i` input, N_REQ*W: operand c, same packing.
- `req_d_i` input, N_REQ*W: operand d, same packing.
- `res_valid_o` output, 1: result valid.
- `res_ready_i` input, 1: result consumer ready.
- `res_data_o` output, W: AOI result.
- `res_id_o` output, ID_W: index of the requester that owns the result.
- `busy_o` output, 1: high whenever the state is not IDLE.

## Operation
State machine with three states: IDLE, EXEC, RESP.

- **IDLE**
  - If any `req_valid_i` bit is set, select grant g (round-robin, see below).
  - Drive `req_ready_o[g]=1` combinationally in the same cycle.
  - At the clock edge, capture g's operands into the operand registers and g into the id register, then go to EXEC.
  - If no request is valid, stay in IDLE with `req_ready_o=0`.
- **EXEC**
  - The operand registers drive `iob_aoi`.
  - At the clock edge, register the AOI output into `res_data_o`, set `res_valid_o=1`, and go to RESP.
- **RESP**
  - Hold `res_valid_o`, `res_data_o` and `res_id_o` stable.
  - When `res_valid_o && res_ready_i`: clear `res_valid_o`, update the round-robin pointer to g, and go to IDLE.
- **Round-robin:** search starts at index `ptr+1` and wraps modulo N_REQ. The first index with a set valid bit wins. The pointer is updated only on a completed result handshake.
- **Requester contract:** a requester holds its operands stable while its valid is high. Dropping valid before ready is legal; the grant is computed only from the current cycle's valids.
- **Ready outside IDLE:** `req_ready_o` is all-zero in EXEC and RESP, and while `rst_n_i=0`.
- **Arithmetic:** bitwise over W bits, no carries; the result width equals W.

## Timing
- **Reset values** (rst_n_i=0 sampled at an edge):
  - state = IDLE, `ptr = N_REQ-1` (so requester 0 has first priority);
  - `res_valid_o=0`, `res_data_o=0`, `res_id_o=0`, `busy_o=0`;
  - operand registers = 0.
- **Latency:** request accepted in cycle T (ready and valid both high), `res_valid_o=1` from cycle T+2.
- **Throughput:** at most one operation per 3 cycles when `res_ready_i` is held high.
- **Backpressure:** RESP lasts for any number of cycles while `res_ready_i=0`; no new grant is issued during that time.
- **Reset mid-operation** (in EXEC or RESP): any in-flight result is discarded. In the following cycle `res_valid_o=0`, and the pointer returns to its reset value.
- **res_ready_i without a result:** `res_ready_i` high while `res_valid_o=0` has no effect.

## Configuration
- `IOB_AOI_SCHED_FIXED_PRIO_EN`
  - **Defined:** round-robin is replaced by fixed priority; the lowest valid index always wins, and the pointer register is not built.
  - **Undefined (default):** round-robin arbitration as described in Operation.
- All other behaviour and all timing are identical in both builds.

## Structure
- Shared package `iob_aoi_sched_pkg`: state encodings `IDLE=2'd0`, `EXEC=2'd1`, `RESP=2'd2`, and the ID width helper.
- Sub-module: the existing `iob_aoi` (parameter `W`), instantiated once and fed by the operand registers.
- The arbiter, operand/id registers and FSM stay in `iob_aoi_sched`.

## Test plan
Configuration for all tests: N_REQ=4, W=4.

1. **Reset:** hold `rst_n_i=0` for 3 cycles with all valids high → `req_ready_o=0000` and `res_valid_o=0` throughout; after release, the first grant goes to requester 0.
2. **Single request:** requester 2 with a=1100, b=1010, c=0011, d=0101 → `res_data_o=0110`, `res_id_o=2`, `res_valid_o` rising 2 cycles after acceptance.
3. **All four requesters continuously valid**, `res_ready_i=1` → ids returned in order 0,1,2,3,0, one result every 3 cycles.
4. **Backpressure:** `res_ready_i=0` for 5 cycles in RESP → data, id and valid stable; `req_ready_o=0000`; `busy_o=1`; on release, returns to IDLE the next cycle.
5. **Reset asserted in EXEC** → next cycle `res_valid_o=0`, `busy_o=0`; with requesters 1 and 3 valid, the next grant goes to 1.
6. **With `IOB_AOI_SCHED_FIXED_PRIO_EN`:** requesters 1 and 3 continuously valid → every result has `res_id_o=1`.

Source files
------------

// File: rtl/iob_aoi_sched_pkg.sv
// ============================================================================
//  Module      : iob_aoi_sched_pkg
//  Description : State encoding and ID-width helper shared by the
//                iob_aoi_sched scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_aoi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width needed to carry a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_aoi.sv
// ============================================================================
//  Module      : iob_aoi
//  Description : Bitwise AND-OR-INVERT gate, y = ~((a & b) | (c & d)).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_aoi #(
    parameter int W = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] y_o
);

    assign y_o = ~((a_i & b_i) | (c_i & d_i));

endmodule

`default_nettype wire

// File: rtl/iob_aoi_sched.sv
// ============================================================================
//  Module      : iob_aoi_sched
//  Description : Round-robin scheduler time-multiplexing one iob_aoi gate
//                between N_REQ valid/ready requesters.
//                Define IOB_AOI_SCHED_FIXED_PRIO_EN for lowest-index-wins
//                arbitration (no pointer register).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_aoi_sched
    import iob_aoi_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int W     = 1,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [N_REQ*W-1:0]   req_a_i,
    input  logic [N_REQ*W-1:0]   req_b_i,
    input  logic [N_REQ*W-1:0]   req_c_i,
    input  logic [N_REQ*W-1:0]   req_d_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [W-1:0]         res_data_o,
    output logic [ID_W-1:0]      res_id_o,
    output logic                 busy_o
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_c;
    logic [W-1:0]    r_d;
    logic [ID_W-1:0] r_id;
    logic [W-1:0]    r_res_data;
    logic            r_res_valid;
    logic [W-1:0]    w_y;
    logic [ID_W-1:0] w_grant;
    logic            w_found;
    logic            w_accept;
    logic            w_handshake;

`ifdef IOB_AOI_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req_valid_i[i]) begin
                w_found = 1'b1;
                w_grant = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] r_ptr;
    int              w_idx;

    // Search begins just after the last served requester and wraps.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(r_ptr) + i) % N_REQ;
            if (!w_found && req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_grant = ID_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ptr <= ID_W'(N_REQ - 1);
        end else if (w_handshake) begin
            r_ptr <= r_id;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (r_res_valid && res_ready_i) begin
                    w_handshake = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant is suppressed during reset even though the FSM may sit in IDLE.
    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = w_accept && rst_n_i && (w_grant == ID_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_id        <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= req_a_i[int'(w_grant)*W +: W];
                r_b  <= req_b_i[int'(w_grant)*W +: W];
                r_c  <= req_c_i[int'(w_grant)*W +: W];
                r_d  <= req_d_i[int'(w_grant)*W +: W];
                r_id <= w_grant;
            end
            if (r_state == EXEC) begin
                r_res_data  <= w_y;
                r_res_valid <= 1'b1;
            end else if (w_handshake) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    iob_aoi #(
        .W (W)
    ) u_aoi (
        .a_i (r_a),
        .b_i (r_b),
        .c_i (r_c),
        .d_i (r_d),
        .y_o (w_y)
    );

    assign res_valid_o = r_res_valid;
    assign res_data_o  = r_res_data;
    assign res_id_o    = r_id;
    assign busy_o      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_iob_aoi_sched.sv
// ============================================================================
//  Module      : tb_iob_aoi_sched
//  Description : Directed and randomized bench for iob_aoi_sched (N_REQ=4,
//                W=4) against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_aoi_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  req_ready;
    logic [15:0] a, b, c, d;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic [1:0]  res_id;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: phase 0 = free, 1 = operation in flight, 2 = result held.
    int         m_phase = 0;
    int         m_ptr   = 3;
    int         m_id    = 0;
    logic [3:0] m_pend  = 4'h0;
    logic [3:0] m_data  = 4'h0;
    bit         m_valid = 1'b0;
    logic [3:0] last_ready;

    iob_aoi_sched #(
        .N_REQ (4),
        .W     (4)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (valid),
        .req_ready_o (req_ready),
        .req_a_i     (a),
        .req_b_i     (b),
        .req_c_i     (c),
        .req_d_i     (d),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_id_o    (res_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
`ifdef IOB_AOI_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
        for (int i = 1; i <= 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
`endif
        return 0;
    endfunction

    task automatic new_ops(input int k);
        a[k*4 +: 4] = 4'($urandom);
        b[k*4 +: 4] = 4'($urandom);
        c[k*4 +: 4] = 4'($urandom);
        d[k*4 +: 4] = 4'($urandom);
    endtask

    // Checks outputs against the model, advances the model, crosses one edge.
    task automatic step();
        logic [3:0] exp_ready;
        #1;
        exp_ready = 4'h0;
        if (rst_n && m_phase == 0 && valid != 4'h0) exp_ready[pick(valid, m_ptr)] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        if (m_valid) begin
            chk("res_data", 32'(res_data), 32'(m_data));
            chk("res_id", 32'(res_id), 32'(m_id));
        end
        last_ready = exp_ready;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 3; m_valid = 1'b0; m_data = 4'h0; m_id = 0;
        end else begin
            case (m_phase)
                0: if (valid != 4'h0) begin
                    m_id   = pick(valid, m_ptr);
                    m_pend = ~((a[m_id*4 +: 4] & b[m_id*4 +: 4]) |
                               (c[m_id*4 +: 4] & d[m_id*4 +: 4]));
                    m_phase = 1;
                end
                1: begin m_data = m_pend; m_valid = 1'b1; m_phase = 2; end
                default: if (res_ready) begin m_valid = 1'b0; m_ptr = m_id; m_phase = 0; end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; valid = 4'hF; res_ready = 1'b1; last_ready = 4'h0;
        for (int k = 0; k < 4; k++) new_ops(k);
        @(posedge clk);
        @(negedge clk);

        // Reset held with all requesters valid, then first grant.
        repeat (3) step();
        chk("rst_data", 32'(res_data), 32'h0);
        chk("rst_id", 32'(res_id), 32'h0);
        rst_n = 1'b1;
        step();
        valid = 4'h0;
        repeat (4) step();

        // Single request from requester 2.
        a[11:8] = 4'b1100; b[11:8] = 4'b1010; c[11:8] = 4'b0011; d[11:8] = 4'b0101;
        valid = 4'b0100;
        step();
        valid = 4'h0;
        step();
        chk("t2_data", 32'(res_data), 32'b0110);
        chk("t2_id", 32'(res_id), 32'd2);

        // Backpressure for 5 cycles in RESP, then release.
        res_ready = 1'b0;
        repeat (5) step();
        res_ready = 1'b1;
        repeat (2) step();

        // Reset during EXEC, then requesters 1 and 3 compete.
        valid = 4'b0001;
        step();
        valid = 4'h0; rst_n = 1'b0;
        step();
        rst_n = 1'b1; valid = 4'b1010;
        step();
        valid = 4'h0;
        repeat (3) step();

        // All four continuously valid, result always taken.
        valid = 4'hF;
        repeat (16) begin
            step();
            for (int k = 0; k < 4; k++) if (last_ready[k]) new_ops(k);
        end
        valid = 4'h0;
        repeat (3) step();

        // Randomized traffic with backpressure and occasional reset.
        repeat (3000) begin
            for (int k = 0; k < 4; k++) begin
                if (valid[k]) begin
                    if (last_ready[k] || $urandom_range(7) == 0) valid[k] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    new_ops(k);
                    valid[k] = 1'b1;
                end
            end
            res_ready = ($urandom_range(3) != 0);
            rst_n     = ($urandom_range(63) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
